// File: rtl/mesh_pkg.sv
// ---------------------------------------------------------------------------
// mesh_pkg
// Shared definitions for the 2D-mesh matrix multiplier result path.
//   drain_state_e : readout FSM states (IDLE, STREAM)
//   MESH_N, ACC_W : default mesh dimension and accumulator width
//   clog2()       : index width helper; returns at least 1
// ---------------------------------------------------------------------------
package mesh_pkg;

  localparam int MESH_N = 3;
  localparam int ACC_W  = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  // Ceiling log2, clamped to 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/mesh_result_drain_if.sv
// ---------------------------------------------------------------------------
// mesh_result_drain_if
// Valid/ready result stream from the drain to its consumer.
//   DOUT  : current result element (W bits)
//   VALID : DOUT holds a result
//   READY : consumer accepts DOUT this cycle
//   LAST  : asserted with VALID on the final element of a snapshot
// Modports: master = drain side, slave = consumer side.
// ---------------------------------------------------------------------------
interface mesh_result_drain_if
  import mesh_pkg::*;
#(
  parameter int W = ACC_W
);

  logic [W-1:0] DOUT;
  logic         VALID;
  logic         READY;
  logic         LAST;

  modport master (
    output DOUT,
    output VALID,
    output LAST,
    input  READY
  );

  modport slave (
    input  DOUT,
    input  VALID,
    input  LAST,
    output READY
  );

endinterface

// File: rtl/drain_idx_ctr.sv
// ---------------------------------------------------------------------------
// drain_idx_ctr
// Element index counter for the result drain.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : synchronous return to 0 (has priority over inc)
//   inc      : advance by one
//   count    : current index, 0 .. COUNT-1
//   tc       : terminal count, high while count == COUNT-1
// The owner never asserts inc at terminal count, so the index cannot wrap.
// ---------------------------------------------------------------------------
module drain_idx_ctr
  import mesh_pkg::*;
#(
  parameter int COUNT = MESH_N * MESH_N,
  parameter int IW    = clog2(COUNT)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          inc,
  output logic [IW-1:0] count,
  output logic          tc
);

  logic [IW-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + IW'(1);
    end
  end

  assign count = count_q;
  assign tc    = (count_q == IW'(COUNT - 1));

endmodule

// File: rtl/mesh_result_drain.sv
// ---------------------------------------------------------------------------
// mesh_result_drain
// Readout engine for the N x N mesh accumulators. A CAPTURE pulse in IDLE
// snapshots every accumulator, pulses CLR_ACC for one cycle, and the snapshot
// is then streamed row-major, one element per accepted beat.
//   CLK, RST : clock, asynchronous active-high reset
//   CAPTURE  : single-cycle "mesh result ready" pulse (ignored while BUSY)
//   ACC_IN   : flattened accumulators, element (r,c) at [(r*N+c)*W +: W]
//   CLR_ACC  : one-cycle clear pulse to the processing elements
//   BUSY     : snapshot held or being streamed
//   bus      : valid/ready result stream (master side)
// Every output comes from a flop or from registered state, so neither READY
// nor CAPTURE has a combinational path to an output.
// ---------------------------------------------------------------------------
module mesh_result_drain
  import mesh_pkg::*;
#(
  parameter int N = MESH_N,
  parameter int W = ACC_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CAPTURE,
  input  logic [N*N*W-1:0]    ACC_IN,
  output logic                CLR_ACC,
  output logic                BUSY,
  mesh_result_drain_if.master bus
);

  localparam int NN = N * N;
  localparam int IW = clog2(NN);

  drain_state_e  state_q;
  drain_state_e  state_d;
  logic          load;
  logic          accept;
  logic          idx_clr;
  logic          idx_inc;
  logic [IW-1:0] idx;
  logic          idx_tc;
  logic          clr_q;
  logic [W-1:0]  snap_q [NN];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that left one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // READY is irrelevant here; only a capture starts a drain.
        if (CAPTURE) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // CAPTURE is deliberately not looked at in this state, including on
        // the final handshake, so a stray pulse neither reloads nor clears.
        if (bus.READY) begin
          accept = 1'b1;
          if (idx_tc) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Index returns to 0 on a new snapshot and after the last beat.
  assign idx_clr = load | (accept & idx_tc);
  assign idx_inc = accept & ~idx_tc;

  drain_idx_ctr #(
    .COUNT (NN),
    .IW    (IW)
  ) u_idx_ctr (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (idx_clr),
    .inc   (idx_inc),
    .count (idx),
    .tc    (idx_tc)
  );

  // -------------------------------------------------------------------------
  // Snapshot buffer. Loaded from ACC_IN on the capture edge itself, so the
  // clear pulse that follows can never reach the stored values.
  // -------------------------------------------------------------------------
  // NOTE: this buffer is small and lives in flops, and reset must leave it
  // holding zeros, so it is reset like any other register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NN; i++) begin
        snap_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NN; i++) begin
        snap_q[i] <= ACC_IN[i*W +: W];
      end
    end
  end

  // Clear pulse is registered: high for exactly the cycle after capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clr_q <= 1'b0;
    end else begin
      clr_q <= load;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only. DOUT is forced to 0 outside
  // STREAM so reset and idle present a clean bus.
  // -------------------------------------------------------------------------
  assign CLR_ACC   = clr_q;
  assign BUSY      = (state_q == STREAM);
  assign bus.VALID = (state_q == STREAM);
  assign bus.LAST  = (state_q == STREAM) && idx_tc;
  assign bus.DOUT  = (state_q == STREAM) ? snap_q[idx] : '0;

endmodule

// File: tb/tb_mesh_result_drain.sv
// ---------------------------------------------------------------------------
// tb_mesh_result_drain
// Self-checking bench for mesh_result_drain (N=3, W=12). Expected elements
// are queued when a snapshot is captured and popped as beats are accepted.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mesh_result_drain;
  import mesh_pkg::*;

  localparam int N      = 3;
  localparam int W      = 12;
  localparam int NN     = N * N;
  localparam int BUDGET = 60;

  logic            CLK;
  logic            RST;
  logic            CAPTURE;
  logic [NN*W-1:0] ACC_IN;
  logic            CLR_ACC;
  logic            BUSY;

  mesh_result_drain_if #(.W(W)) bus ();

  mesh_result_drain #(
    .N (N),
    .W (W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CAPTURE (CAPTURE),
    .ACC_IN  (ACC_IN),
    .CLR_ACC (CLR_ACC),
    .BUSY    (BUSY),
    .bus     (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int           n_cmp;
  int           n_err;
  logic [W-1:0] exp_q [$];

  function automatic logic [NN*W-1:0] mk_seq(input int base);
    logic [NN*W-1:0] v;
    for (int i = 0; i < NN; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  function automatic logic [NN*W-1:0] mk_fill(input logic [W-1:0] val);
    logic [NN*W-1:0] v;
    for (int i = 0; i < NN; i++) v[i*W +: W] = val;
    return v;
  endfunction

  // Called on a falling edge with the DUT idle. Captures at the next rising
  // edge and returns on the falling edge after it (first beat visible).
  task automatic do_capture(input logic [NN*W-1:0] data, input bit flood);
    ACC_IN  = data;
    CAPTURE = 1'b1;
    for (int i = 0; i < NN; i++) exp_q.push_back(data[i*W +: W]);
    @(negedge CLK);
    CAPTURE = 1'b0;
    if (flood) ACC_IN = mk_fill(12'hFFF);
    n_cmp++;
    if (CLR_ACC !== 1'b1) begin
      n_err++; $display("FAIL capture_clr: CLR_ACC=%b want 1", CLR_ACC);
    end
    n_cmp++;
    if (bus.VALID !== 1'b1 || BUSY !== 1'b1) begin
      n_err++; $display("FAIL capture_start: VALID=%b BUSY=%b want 1 1", bus.VALID, BUSY);
    end
    n_cmp++;
    if (bus.DOUT !== data[W-1:0]) begin
      n_err++; $display("FAIL capture_first: DOUT=%h want %h", bus.DOUT, data[W-1:0]);
    end
  endtask

  // Consumes beats from the scoreboard. mode 0: READY always high,
  // mode 1: READY pattern 1,0,0,1. Optionally injects CAPTURE mid-stream
  // and/or on the final handshake.
  task automatic drain(input int mode, input int max_beats, input bit cap_mid,
                       input bit cap_last, output int cycles);
    int           beats;
    int           clr_extra;
    bit           rdy;
    bit           holding;
    logic [W-1:0] held_d;
    logic         held_l;
    logic [W-1:0] e;
    beats     = 0;
    clr_extra = 0;
    holding   = 1'b0;
    held_d    = '0;
    held_l    = 1'b0;
    cycles    = 0;
    while (exp_q.size() > 0 && beats < max_beats && cycles < BUDGET) begin
      if (cycles > 0 && CLR_ACC !== 1'b0) clr_extra++;
      n_cmp++;
      if (bus.VALID !== 1'b1 || BUSY !== 1'b1) begin
        n_err++; $display("FAIL valid_held: VALID=%b BUSY=%b want 1 1 (beat %0d)", bus.VALID, BUSY, beats);
      end
      if (holding) begin
        n_cmp++;
        if (bus.DOUT !== held_d || bus.LAST !== held_l) begin
          n_err++; $display("FAIL stall_stable: DOUT=%h LAST=%b want %h %b", bus.DOUT, bus.LAST, held_d, held_l);
        end
      end
      rdy = (mode == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
      bus.READY = rdy;
      CAPTURE   = (cap_mid && beats == 3) || (cap_last && exp_q.size() == 1 && rdy);
      if (CAPTURE) ACC_IN = mk_seq(12'h7A0);
      if (rdy) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.DOUT !== e) begin
          n_err++; $display("FAIL beat_data: DOUT=%h want %h (beat %0d)", bus.DOUT, e, beats);
        end
        n_cmp++;
        if (bus.LAST !== (exp_q.size() == 0)) begin
          n_err++; $display("FAIL beat_last: LAST=%b want %b (beat %0d)", bus.LAST, exp_q.size() == 0, beats);
        end
        holding = 1'b0;
        beats++;
      end else begin
        holding = 1'b1;
        held_d  = bus.DOUT;
        held_l  = bus.LAST;
      end
      @(negedge CLK);
      cycles++;
    end
    CAPTURE   = 1'b0;
    bus.READY = 1'b0;
    if (cycles >= BUDGET) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d cycles want < %0d", cycles, BUDGET);
    end
    n_cmp++;
    if (clr_extra != 0) begin
      n_err++; $display("FAIL clr_single: extra CLR_ACC cycles=%0d want 0", clr_extra);
    end
    if (exp_q.size() == 0) begin
      n_cmp++;
      if (BUSY !== 1'b0 || bus.VALID !== 1'b0 || CLR_ACC !== 1'b0) begin
        n_err++; $display("FAIL drain_end: BUSY=%b VALID=%b CLR_ACC=%b want 0 0 0", BUSY, bus.VALID, CLR_ACC);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (bus.VALID !== 1'b0 || bus.LAST !== 1'b0 || BUSY !== 1'b0 || CLR_ACC !== 1'b0 || bus.DOUT !== '0) begin
      n_err++;
      $display("FAIL %s: VALID=%b LAST=%b BUSY=%b CLR_ACC=%b DOUT=%h want all 0",
               tag, bus.VALID, bus.LAST, BUSY, CLR_ACC, bus.DOUT);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_all_zero("reset_outputs");
    RST       = 1'b0;
    bus.READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.VALID !== 1'b0 || CLR_ACC !== 1'b0) begin
        n_err++; $display("FAIL idle_quiet: VALID=%b CLR_ACC=%b want 0 0", bus.VALID, CLR_ACC);
      end
    end
    bus.READY = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    do_capture(mk_seq(1), 1'b0);
    drain(0, NN, 1'b0, 1'b0, cyc);
    n_cmp++;
    if (cyc != NN) begin
      n_err++; $display("FAIL throughput: drain cycles=%0d want %0d", cyc, NN);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge CLK);
    do_capture(mk_seq(1), 1'b0);
    drain(1, NN, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_snapshot_isolation();
    int cyc;
    @(negedge CLK);
    do_capture(mk_seq(1), 1'b1);
    drain(0, NN, 1'b0, 1'b0, cyc);
    @(negedge CLK);
    do_capture(mk_fill(12'hFFF), 1'b0);
    drain(1, NN, 1'b0, 1'b0, cyc);
    @(negedge CLK);
    do_capture(mk_seq($urandom_range(0, 4000)), 1'b0);
    drain(0, NN, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_capture_busy();
    int cyc;
    @(negedge CLK);
    do_capture(mk_seq(12'h200), 1'b0);
    drain(0, NN, 1'b1, 1'b1, cyc);
    // Capture right after BUSY fell starts a fresh drain.
    do_capture(mk_seq(12'h300), 1'b0);
    drain(0, NN, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_reset_mid_stream();
    int cyc;
    @(negedge CLK);
    do_capture(mk_seq(12'h400), 1'b0);
    drain(0, 4, 1'b0, 1'b0, cyc);
    RST = 1'b1;
    #1;
    check_all_zero("reset_mid_stream");
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_all_zero("after_reset_idle");
    do_capture(mk_seq(12'h500), 1'b0);
    drain(0, NN, 1'b0, 1'b0, cyc);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    RST       = 1'b1;
    CAPTURE   = 1'b0;
    ACC_IN    = '0;
    bus.READY = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot_isolation();
    test_capture_busy();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mesh_result_drain.md
# mesh_result_drain

Readout engine for the 2D-mesh matrix multiplier. When the mesh finishes a product it pulses CAPTURE. The drain then snapshots all N×N 12-bit accumulator values in parallel and issues a one-cycle clear to the processing elements. It streams the snapshot out row-major, one element per accepted beat, over a valid/ready interface. It is the reading end of the per-PE accumulator registers and sits between the mesh array and the result consumer (host port or next pipeline stage).

## Interface
Parameters:
- N, 3, mesh dimension (N×N PEs, N ≥ 2)
- W, 12, accumulator/result width in bits

Ports:
- RST  in  1  asynchronous reset, active-high
- CLK  in  1  clock, all state on rising edge
- CAPTURE  in  1  single-cycle pulse: mesh result ready
- ACC_IN  in  N*N*W  flattened accumulators; element (r,c) at bits [(r*N+c)*W +: W]
- CLR_ACC  out  1  one-cycle pulse to PE enables (drives EN low → accumulators clear)
- BUSY  out  1  high while a snapshot is being held or streamed
- DOUT  out  W  current result element
- VALID  out  1  DOUT valid
- READY  in  1  consumer accepts DOUT
- LAST  out  1  high with VALID on element N*N-1

## Operation
- States: IDLE, STREAM.
- IDLE: BUSY=0, VALID=0, and the DOUT value is unspecified.
  - On CAPTURE=1, latch all N*N elements of ACC_IN into the snapshot buffer, set index to 0, pulse CLR_ACC, and go to STREAM.
- STREAM: BUSY=1, VALID=1, DOUT=buf[index], LAST=(index==N*N-1).
  - On VALID&READY with index<N*N-1: index+1.
  - On VALID&READY with LAST: go to IDLE.
- Handshake: DOUT and LAST stay stable while VALID=1 and READY=0. VALID is never withdrawn before acceptance.
- CAPTURE while BUSY=1 is ignored. That includes the cycle of the final handshake. No snapshot is taken and no CLR_ACC pulse is issued. The mesh controller must not capture while BUSY.
- READY while in IDLE has no effect.
- Values pass through unmodified. There is no saturation or sign handling; W bits in, W bits out.
- Index width is clog2(N*N). The index never wraps past N*N-1; the return to IDLE resets it to 0.

## Timing
- Reset (RST=1, any time, including mid-stream): state=IDLE, index=0, buffer cleared to 0. Outputs are VALID=0, LAST=0, BUSY=0, CLR_ACC=0, DOUT=0. Any stream in progress is abandoned and no partial completion is signalled.
- CAPTURE sampled at edge k:
  - VALID, BUSY, and element 0 on DOUT are visible after edge k.
  - CLR_ACC is high for exactly the cycle after edge k.
  - The snapshot uses the ACC_IN value present at edge k, so the clear cannot corrupt it.
- Throughput is one element per cycle with READY held high. A full drain takes N*N cycles from the first VALID cycle; BUSY drops after the edge that accepts LAST.
- Earliest next CAPTURE is the cycle after BUSY falls.
- All outputs are registered or decoded only from registered state. There are no combinational paths from READY or CAPTURE to any output.

## Structure
- Shared package mesh_pkg holds:
  - the state enum (IDLE, STREAM);
  - constants MESH_N=3 and ACC_W=12, which serve as the parameter defaults;
  - an index-width function clog2.
- Sub-module drain_idx_ctr: an up-counter with clear, increment enable, and terminal-count flag (count==N*N-1). The top level holds the snapshot buffer, the FSM and the output mux.

## Test plan
- Reset/idle: assert RST mid-operation → all outputs 0 in the same cycle. CAPTURE held 0 → VALID stays 0.
- Basic drain (N=3): ACC_IN elements = 1..9, one CAPTURE pulse, READY=1 → DOUT 1,2,…,9 on consecutive cycles, LAST only with 9, CLR_ACC high for exactly one cycle, BUSY falls after beat 9.
- Backpressure: same data, READY toggling 1,0,0,1,… → every element appears exactly once and in order, and DOUT/LAST stay stable during READY=0 cycles.
- Snapshot isolation: change ACC_IN to all 0xFFF the cycle after CAPTURE → the streamed values are still 1..9. The extreme value 0xFFF captured in a separate run streams out unaltered.
- Capture while busy: a second CAPTURE mid-stream, and another in the same cycle as the final handshake → both ignored, no extra CLR_ACC pulse. A CAPTURE one cycle after BUSY falls starts a new drain.
- Reset mid-stream: RST after element 4 is accepted → IDLE immediately. A following CAPTURE with new data streams from element 0.
